// File: rtl/alu_bist_seq.sv
// BIST sequencer for an ALU: walks every opcode through NUM_PATTERNS LFSR operand
// patterns (LOAD/SETTLE/CAPTURE), then compares the MISR signature against golden.
module alu_bist_seq #(
  parameter int WIDTH        = 24,
  parameter int NUM_PATTERNS = 16,
  parameter int NUM_OPS      = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] golden_i,
  input  logic [WIDTH-1:0] signature_i,
  output logic             lfsr_en_o,
  output logic             misr_en_o,
  output logic             misr_clr_o,
  output logic [3:0]       cntrl_alu_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o
);

  // A single-pattern build still needs a 1-bit counter to keep the ports legal.
  localparam int PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PATTERNS - 1);
  localparam logic [3:0]    OP_LAST  = 4'(NUM_OPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pat_q, pat_d;
  logic [3:0]      op_q, op_d;
  logic            pass_q, pass_d;
  logic            busy;

  assign busy = state_q inside {S_CLEAR, S_LOAD, S_SETTLE, S_CAPTURE, S_COMPARE};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      op_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      op_q    <= op_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    op_d    = op_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          pass_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        pat_d   = '0;
        op_d    = '0;
        pass_d  = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (pat_q != PAT_LAST) begin
          pat_d   = pat_q + PW'(1);
          state_d = S_LOAD;
        end else if (op_q != OP_LAST) begin
          pat_d   = '0;
          op_d    = op_q + 4'd1;
          state_d = S_LOAD;
        end else begin
          // Counters return to 0 so the opcode output reads 0 once back in IDLE.
          pat_d   = '0;
          op_d    = '0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        pass_d  = (signature_i == golden_i);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort beats every busy-state transition, including CAPTURE->COMPARE.
    if (abort_i && busy) begin
      state_d = S_IDLE;
      pat_d   = '0;
      op_d    = '0;
      pass_d  = 1'b0;
    end
  end

  assign lfsr_en_o   = (state_q == S_LOAD);
  assign misr_en_o   = (state_q == S_CAPTURE);
  assign misr_clr_o  = (state_q == S_CLEAR);
  assign cntrl_alu_o = op_q;
  assign busy_o      = busy;
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = pass_q;

endmodule

// File: tb/tb_alu_bist_seq.sv
// Bench for alu_bist_seq: one instance at 4 patterns x 15 ops, one at 1 x 1, both
// tracked every cycle by a run-position model plus directed scenario records.
module tb_alu_bist_seq;

  localparam int W  = 24;
  localparam int PA = 4;
  localparam int OA = 15;
  localparam int PB = 1;
  localparam int OB = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, start_i, abort_i;
  logic [W-1:0]  golden_i, signature_i;

  logic       a_lfsr, a_men, a_clr, a_busy, a_done, a_pass;
  logic [3:0] a_op;
  logic       b_lfsr, b_men, b_clr, b_busy, b_done, b_pass;
  logic [3:0] b_op;

  alu_bist_seq #(.WIDTH(W), .NUM_PATTERNS(PA), .NUM_OPS(OA)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .golden_i(golden_i), .signature_i(signature_i),
    .lfsr_en_o(a_lfsr), .misr_en_o(a_men), .misr_clr_o(a_clr),
    .cntrl_alu_o(a_op), .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass)
  );

  alu_bist_seq #(.WIDTH(W), .NUM_PATTERNS(PB), .NUM_OPS(OB)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .golden_i(golden_i), .signature_i(signature_i),
    .lfsr_en_o(b_lfsr), .misr_en_o(b_men), .misr_clr_o(b_clr),
    .cntrl_alu_o(b_op), .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       lfsr;
    logic       men;
    logic       mclr;
    logic [3:0] op;
    logic       pass;
  } obs_t;

  // Reference model: a run is a position counter (0 = idle, 1 = clear, then three
  // cycles per pattern, then compare and done); outputs follow from arithmetic on it.
  int   pos_a = 0, pos_b = 0;
  logic pass_a = 1'b0, pass_b = 1'b0;

  function automatic obs_t model_obs(input int pos, input int p, input int o,
                                     input logic pass, output logic op_care);
    obs_t e;
    int   k;
    e       = '0;
    e.pass  = pass;
    op_care = 1'b1;
    if (pos == 1) begin
      e.busy = 1'b1;
      e.mclr = 1'b1;
    end else if (pos >= 2 && pos <= 3*p*o + 1) begin
      k      = pos - 2;
      e.busy = 1'b1;
      e.lfsr = (k % 3 == 0);
      e.men  = (k % 3 == 2);
      e.op   = 4'(k / (3*p));
    end else if (pos == 3*p*o + 2) begin
      e.busy  = 1'b1;
      op_care = 1'b0;
    end else if (pos == 3*p*o + 3) begin
      e.done  = 1'b1;
      op_care = 1'b0;
    end
    return e;
  endfunction

  task automatic model_step(inout int pos, inout logic pass, input int p, input int o);
    int last;
    last = 3*p*o + 3;
    if (rst_i) begin
      pos  = 0;
      pass = 1'b0;
    end else if (pos == 0) begin
      if (start_i) begin
        pos  = 1;
        pass = 1'b0;
      end
    end else if (abort_i && pos < last) begin
      pos  = 0;
      pass = 1'b0;
    end else if (pos == last) begin
      pos = 0;
    end else begin
      if (pos == last - 1) pass = (signature_i == golden_i);
      pos++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_inst(input string name, input obs_t act, input int pos,
                            input int p, input int o, input logic pass);
    obs_t e;
    logic care;
    e = model_obs(pos, p, o, pass, care);
    if (!care) act.op = e.op;
    tests++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d pos=%0d got{busy,done,lfsr,men,clr,op,pass}=%b exp=%b",
               name, cyc, pos, act, e);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic st, input logic ab, input logic rs);
    start_i = st;
    abort_i = ab;
    rst_i   = rs;
    @(posedge clk);
    model_step(pos_a, pass_a, PA, OA);
    model_step(pos_b, pass_b, PB, OB);
    #1;
    cyc++;
    check_inst("model_a", obs_t'({a_busy, a_done, a_lfsr, a_men, a_clr, a_op, a_pass}),
               pos_a, PA, OA, pass_a);
    check_inst("model_b", obs_t'({b_busy, b_done, b_lfsr, b_men, b_clr, b_op, b_pass}),
               pos_b, PB, OB, pass_b);
  endtask

  // ---------------- directed scenario table ----------------
  typedef struct {
    int           abort_cyc;   // -1: no abort; else abort_i high during that cycle
    logic [W-1:0] gold;
    logic [W-1:0] sig;
    int           exp_done;    // cycle of done_o, 0 if none
    logic         exp_pass;
    int           exp_lfsr;
    int           exp_men;
  } vec_t;

  vec_t vecs[5];

  // Starts a run on dut_a at edge 0 (must be idle) and observes cycles 1..190.
  task automatic run_vec(input vec_t v, input string tag);
    int done_cyc, nl, nm, nd;
    done_cyc = 0; nl = 0; nm = 0; nd = 0;
    golden_i    = v.gold;
    signature_i = v.sig;
    tick(1'b1, 1'b0, 1'b0);
    chk({tag, "_clr_c1"}, int'(a_clr), 1);
    for (int c = 2; c <= 190; c++) begin
      tick(1'b0, (v.abort_cyc >= 0) && (c == v.abort_cyc + 1), 1'b0);
      if (a_lfsr) nl++;
      if (a_men) nm++;
      if (a_done) begin
        nd++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (v.abort_cyc >= 0 && c == v.abort_cyc + 1)
        chk({tag, "_abort_outs"}, int'({a_busy, a_done, a_pass, a_op}), 0);
    end
    chk({tag, "_done_cyc"}, done_cyc, v.exp_done);
    chk({tag, "_done_cnt"}, nd, (v.exp_done != 0) ? 1 : 0);
    chk({tag, "_pass"}, int'(a_pass), int'(v.exp_pass));
    chk({tag, "_lfsr_cnt"}, nl, v.exp_lfsr);
    chk({tag, "_misr_cnt"}, nm, v.exp_men);
  endtask

  logic [4:0] b_seq[8];

  initial begin
    int d1, d2, nclr;
    logic [4:0] b_act;

    vecs[0] = '{-1,  24'hABCDE0, 24'hABCDE0, 183, 1'b1, 60, 60};
    vecs[1] = '{50,  24'hABCDE0, 24'hABCDE0, 0,   1'b0, 17, 16};
    vecs[2] = '{-1,  24'hABCDE1, 24'hABCDE0, 183, 1'b0, 60, 60};
    vecs[3] = '{181, 24'hABCDE0, 24'hABCDE0, 0,   1'b0, 60, 60};
    vecs[4] = '{182, 24'hABCDE0, 24'hABCDE0, 0,   1'b0, 60, 60};

    // {busy, done, lfsr, men, clr} for the 1x1 instance, cycles 0..7
    b_seq[0] = 5'b00000; b_seq[1] = 5'b10001; b_seq[2] = 5'b10100; b_seq[3] = 5'b10000;
    b_seq[4] = 5'b10010; b_seq[5] = 5'b10000; b_seq[6] = 5'b01000; b_seq[7] = 5'b00000;

    golden_i    = '0;
    signature_i = '0;

    // Reset with start and abort also high: reset must win.
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("reset_outs_a", int'({a_busy, a_done, a_pass, a_lfsr, a_men, a_clr, a_op}), 0);
    chk("reset_outs_b", int'({b_busy, b_done, b_pass, b_lfsr, b_men, b_clr, b_op}), 0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    chk("idle_no_start", int'(a_busy), 0);

    // Boundary: 1 pattern x 1 op gives CLEAR LOAD SETTLE CAPTURE COMPARE DONE.
    golden_i    = 24'h123456;
    signature_i = 24'h123456;
    tick(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick(1'b0, 1'b0, 1'b0);
      b_act = {b_busy, b_done, b_lfsr, b_men, b_clr};
      chk($sformatf("b_seq_c%0d", c), int'(b_act), int'(b_seq[c]));
    end
    chk("b_pass", int'(b_pass), 1);
    tick(1'b0, 1'b0, 1'b1);

    // Table: nominal, abort, fail, abort at CAPTURE->COMPARE boundary, abort in COMPARE.
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-run during CAPTURE of op 7 (cycle 88), then a fresh full run.
    golden_i    = 24'hABCDE0;
    signature_i = 24'hABCDE0;
    tick(1'b1, 1'b0, 1'b0);
    for (int c = 2; c <= 89; c++) begin
      tick(1'b0, 1'b0, c == 89);
      if (c == 88) begin
        chk("capture_op7_men", int'(a_men), 1);
        chk("capture_op7_op", int'(a_op), 7);
      end
    end
    chk("midrun_reset_outs", int'({a_busy, a_done, a_pass, a_lfsr, a_men, a_clr, a_op}), 0);
    run_vec(vecs[0], "after_rst");

    // Start held high: back-to-back runs separated by exactly one IDLE cycle.
    d1 = 0; d2 = 0; nclr = 0;
    for (int c = 1; c <= 380; c++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (a_done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (a_clr && c <= 366) nclr++;
      if (c == 184) chk("held_idle_gap", int'(a_busy), 0);
    end
    chk("held_done1", d1, 183);
    chk("held_done2", d2, 367);
    chk("held_clr_cnt", nclr, 2);

    // Randomized traffic against the model: random start, rare abort/reset.
    for (int i = 0; i < 4000; i++) begin
      signature_i = W'($urandom);
      golden_i    = ($urandom_range(0, 1) == 1) ? signature_i
                                                : signature_i ^ (W'(1) << $urandom_range(0, W-1));
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 999) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
